// File: rtl/dot_product_pkg.sv
// Shared types and helpers for the streaming dot-product unit.
package dot_product_pkg;

  localparam int unsigned LEN_MAX = 64;

  typedef enum logic {
    LOAD_A,
    LOAD_B
  } state_e;

  // Worst-case sum of LEN full-scale products fits without wrap in this width.
  function automatic int unsigned out_width(int unsigned width, int unsigned len);
    return 2 * width + $clog2(len);
  endfunction

endpackage

// File: rtl/dot_product_stream_if.sv
// Word-serial input and scalar result bundle for dot_product_stream.
interface dot_product_stream_if
  import dot_product_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN   = 3
);
  localparam int unsigned OUT_W = out_width(WIDTH, LEN);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             clear;
  logic [OUT_W-1:0] dout;
  logic             run;
  logic             phase_b;

  modport master (
    output din, din_valid, clear,
    input  dout, run, phase_b
  );

  modport slave (
    input  din, din_valid, clear,
    output dout, run, phase_b
  );

endinterface

// File: rtl/dp_mac.sv
// Combinational multiply-accumulate: sum = acc + a*b.
// DOT_PRODUCT_SIGNED_EN selects two's-complement operands.
module dp_mac #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OUT_W = 18
) (
  input  logic [OUT_W-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [OUT_W-1:0] sum_o
);

`ifdef DOT_PRODUCT_SIGNED_EN
  logic signed [2*WIDTH-1:0] prod;
  assign prod  = (2*WIDTH)'($signed(a_i)) * (2*WIDTH)'($signed(b_i));
  // The size cast of a signed product sign-extends into the accumulator width.
  assign sum_o = acc_i + OUT_W'(prod);
`else
  logic [2*WIDTH-1:0] prod;
  assign prod  = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
  assign sum_o = acc_i + OUT_W'(prod);
`endif

endmodule

// File: rtl/dot_product_stream.sv
// Streaming dot product: LEN "a" words, then LEN "b" words, one-cycle run pulse on completion.
// Build with DOT_PRODUCT_SIGNED_EN for two's-complement arithmetic.
module dot_product_stream
  import dot_product_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN   = 3
) (
  input logic                 clk,
  input logic                 reset,
  dot_product_stream_if.slave bus
);

  localparam int unsigned      OUT_W    = out_width(WIDTH, LEN);
  localparam int unsigned      IDX_W    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

  if (LEN < 1 || LEN > LEN_MAX) begin : g_len_check
    $error("dot_product_stream: LEN out of range");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic [OUT_W-1:0] mac_sum;
  logic             run_q, run_d;
  logic             a_we;
  logic             last;
  logic [WIDTH-1:0] a_q [LEN];

  assign last = (idx_q == IDX_LAST);

  dp_mac #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_mac (
    .acc_i (acc_q),
    .a_i   (a_q[idx_q]),
    .b_i   (bus.din),
    .sum_o (mac_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // clear takes priority over a simultaneous beat, which is dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    run_d   = 1'b0;
    a_we    = 1'b0;
    if (bus.clear) begin
      state_d = LOAD_A;
      idx_d   = '0;
      acc_d   = '0;
    end else if (bus.din_valid) begin
      unique case (state_q)
        LOAD_A: begin
          a_we = 1'b1;
          if (last) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        LOAD_B: begin
          if (last) begin
            dout_d  = mac_sum;
            run_d   = 1'b1;
            acc_d   = '0;
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            acc_d = mac_sum;
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_comb begin
    bus.phase_b = (state_q == LOAD_B);
    bus.run     = run_q;
    bus.dout    = dout_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      acc_q  <= '0;
      dout_q <= '0;
      run_q  <= 1'b0;
      for (int i = 0; i < LEN; i++) begin
        a_q[i] <= '0;
      end
    end else begin
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
      run_q  <= run_d;
      if (a_we) begin
        a_q[idx_q] <= bus.din;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_stream.sv
// Directed self-checking bench for dot_product_stream (default and small/large parameter sets).
module tb_dot_product_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   run_count = 0;

  always #5 clk = ~clk;

  dot_product_stream_if #(.WIDTH(8), .LEN(3)) bus ();
  dot_product_stream_if #(.WIDTH(4), .LEN(1)) bus1 ();
  dot_product_stream_if #(.WIDTH(16), .LEN(8)) bus8 ();

  dot_product_stream #(.WIDTH(8), .LEN(3)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dot_product_stream #(.WIDTH(4), .LEN(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  dot_product_stream #(.WIDTH(16), .LEN(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  always @(negedge clk) begin
    if (bus.run === 1'b1) run_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus.din       = d;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] d);
    repeat ($urandom_range(0, 5)) tick();
    send(d);
  endtask

  logic [17:0]     e18;
  logic [15:0]     va [8];
  logic [15:0]     vb [8];
  longint unsigned model;

  initial begin
    bus.din = '0;   bus.din_valid = 1'b0;  bus.clear = 1'b0;
    bus1.din = '0;  bus1.din_valid = 1'b0; bus1.clear = 1'b0;
    bus8.din = '0;  bus8.din_valid = 1'b0; bus8.clear = 1'b0;
    tick();
    tick();
    check("reset_dout", 64'(bus.dout), 64'd0);
    check("reset_run", 64'(bus.run), 64'd0);
    check("reset_phase_b", 64'(bus.phase_b), 64'd0);
    reset = 1'b0;
    tick();

`ifndef DOT_PRODUCT_SIGNED_EN
    // Basic vector with continuous valid
    send(1); send(2); send(3);
    check("basic_phase_b_hi", 64'(bus.phase_b), 64'd1);
    check("basic_run_early", 64'(bus.run), 64'd0);
    send(4); send(5); send(6);
    check("basic_run", 64'(bus.run), 64'd1);
    check("basic_dout", 64'(bus.dout), 64'd32);
    check("basic_phase_b_lo", 64'(bus.phase_b), 64'd0);
    tick();
    check("basic_run_drop", 64'(bus.run), 64'd0);
    check("basic_dout_hold", 64'(bus.dout), 64'd32);

    // Full-scale operands, then zero a with full-scale b
    repeat (6) send(8'hFF);
    check("max_run", 64'(bus.run), 64'd1);
    check("max_dout", 64'(bus.dout), 64'd195075);
    send(0); send(0); send(0);
    send(8'hFF); send(8'hFF); send(8'hFF);
    check("zero_run", 64'(bus.run), 64'd1);
    check("zero_dout", 64'(bus.dout), 64'd0);
    tick();

    // Stalls then a back-to-back vector starting in the run cycle
    run_count = 0;
    send_gap(1); send_gap(2); send_gap(3);
    send_gap(4); send_gap(5); send_gap(6);
    check("stall_run", 64'(bus.run), 64'd1);
    check("stall_dout", 64'(bus.dout), 64'd32);
    send(7);
    check("b2b_run_drop", 64'(bus.run), 64'd0);
    send(7); send(7); send(1); send(1); send(1);
    check("b2b_dout", 64'(bus.dout), 64'd21);
    tick();
    tick();
    check("b2b_run_pulses", 64'(run_count), 64'd2);

    // clear with the 5th beat, then clear with a final b beat
    send(1); send(2); send(3); send(4);
    bus.clear = 1'b1;
    send(5);
    bus.clear = 1'b0;
    check("clear_run", 64'(bus.run), 64'd0);
    check("clear_phase_b", 64'(bus.phase_b), 64'd0);
    check("clear_dout", 64'(bus.dout), 64'd21);
    send(1); send(1); send(1); send(1); send(1);
    bus.clear = 1'b1;
    send(1);
    bus.clear = 1'b0;
    check("clear_last_run", 64'(bus.run), 64'd0);
    check("clear_last_dout", 64'(bus.dout), 64'd21);
    send(2); send(0); send(0); send(3); send(0); send(0);
    check("after_clear_run", 64'(bus.run), 64'd1);
    check("after_clear_dout", 64'(bus.dout), 64'd6);

    // Asynchronous reset mid-vector
    send(9); send(9); send(9); send(9);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_dout", 64'(bus.dout), 64'd0);
    check("rst_mid_run", 64'(bus.run), 64'd0);
    check("rst_mid_phase_b", 64'(bus.phase_b), 64'd0);
    tick();
    reset = 1'b0;
    send(1); send(2); send(3); send(4); send(5); send(6);
    check("post_rst_dout", 64'(bus.dout), 64'd32);

    // LEN=1, WIDTH=4
    bus1.din = 4'd15; bus1.din_valid = 1'b1;
    tick();
    check("len1_phase_b", 64'(bus1.phase_b), 64'd1);
    tick();
    bus1.din_valid = 1'b0;
    check("len1_run", 64'(bus1.run), 64'd1);
    check("len1_dout", 64'(bus1.dout), 64'd225);

    // LEN=8, WIDTH=16 against a reference sum; first vector is full scale
    for (int v = 0; v < 40; v++) begin
      model = 0;
      for (int i = 0; i < 8; i++) begin
        va[i] = (v == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
        vb[i] = (v == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
        model += longint'(va[i]) * longint'(vb[i]);
      end
      bus8.din_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin bus8.din = va[i]; tick(); end
      for (int i = 0; i < 8; i++) begin bus8.din = vb[i]; tick(); end
      bus8.din_valid = 1'b0;
      check("len8_run", 64'(bus8.run), 64'd1);
      check("len8_dout", 64'(bus8.dout), model);
    end
`else
    send(8'hFF); send(2); send(8'h80);
    send(4); send(8'hFB); send(8'h80);
    check("signed1_run", 64'(bus.run), 64'd1);
    check("signed1_dout", 64'(bus.dout), 64'd16370);
    send(8'h80); send(8'h80); send(8'h80);
    send(8'd127); send(8'd127); send(8'd127);
    e18 = -18'sd48768;
    check("signed2_run", 64'(bus.run), 64'd1);
    check("signed2_dout", 64'(bus.dout), 64'(e18));
    bus1.din = 4'hF; bus1.din_valid = 1'b1;
    tick();
    tick();
    bus1.din_valid = 1'b0;
    check("signed_len1_dout", 64'(bus1.dout), 64'd1);
    tick();
    check("signed_run_drop", 64'(bus.run), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
